// File: rtl/npc_pkg.sv
// Shared definitions for the NPC sequencing controller.
// Holds the opcode constants, the special instruction words, the trap cause
// encodings and the controller state enum.
package npc_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef enum logic [1:0] {
    TrapNone    = 2'd0,
    TrapEbreak  = 2'd1,
    TrapIllegal = 2'd2,
    TrapAlign   = 2'd3  // misaligned jump target or fetch timeout
  } trap_cause_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_e;

endpackage

// File: rtl/npc_inst_class.sv
// Combinational instruction classifier for the NPC core.
// Ports:
//   ir        - instruction word held in the IR
//   legal     - encoding is one of the supported instructions (ebreak included)
//   is_ebreak - ir is exactly the ebreak word
//   is_jal    - jal
//   is_jalr   - jalr with funct3 000
//   writes_rd - legal, not ebreak, and rd (ir[11:7]) is nonzero
module npc_inst_class
  import npc_pkg::*;
(
  input  logic [31:0] ir,
  output logic        legal,
  output logic        is_ebreak,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        writes_rd
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rd     = ir[11:7];

  always_comb begin
    legal     = 1'b0;
    is_ebreak = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    if (ir == EBREAK_INST) begin
      legal     = 1'b1;
      is_ebreak = 1'b1;
    end else begin
      unique case (opcode)
        OPC_OP_IMM:         legal = (funct3 == 3'b000);
        OPC_LUI, OPC_AUIPC: legal = 1'b1;
        OPC_JAL: begin
          legal  = 1'b1;
          is_jal = 1'b1;
        end
        OPC_JALR: begin
          legal   = (funct3 == 3'b000);
          is_jalr = (funct3 == 3'b000);
        end
        default: ;
      endcase
    end
    writes_rd = legal && !is_ebreak && (rd != 5'd0);
  end

endmodule

// File: rtl/npc_ctrl.sv
// Multi-cycle sequencing controller for the NPC core.
// Owns PC and IR, fetches over a req/valid handshake, classifies the
// instruction, gates register-file writes, selects the next PC, counts retired
// instructions and halts on ebreak, illegal encoding, misaligned jump target or
// fetch timeout.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   imem_req/imem_addr  - fetch request (held until imem_rvalid) and address (= pc)
//   imem_rvalid/rdata   - single-cycle fetch response and instruction word
//   pc_target           - jump target from the datapath, sampled in EXEC
//   pc, ir, ir_valid    - current instruction address/word; ir_valid in DECODE..WB
//   rf_we               - register-file write strobe, WB only, rd != x0
//   halt, trap_cause    - sticky stop flag and its cause
//   instret             - retired-instruction counter (wraps)
module npc_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic [31:0]      pc_target,
  output logic [31:0]      pc,
  output logic [31:0]      ir,
  output logic             ir_valid,
  output logic             rf_we,
  output logic             halt,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [7:0] TimeoutLast = 8'(FETCH_TIMEOUT - 1);

  state_e           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      ir_q;
  logic [31:0]      target_q;
  logic [7:0]       tcnt_q;
  trap_cause_e      cause_q;
  logic [CNT_W-1:0] instret_q;
  logic             imem_req_q;
  logic             rf_we_q;
  logic             halt_q;
  logic             ir_valid_q;

  logic legal, is_ebreak, is_jal, is_jalr, writes_rd;
  logic is_jump;
  logic [31:0] jump_target;
  logic [31:0] next_pc;

  npc_inst_class u_inst_class (
    .ir        (ir_q),
    .legal     (legal),
    .is_ebreak (is_ebreak),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .writes_rd (writes_rd)
  );

  assign is_jump     = is_jal || is_jalr;
  // jalr clears bit 0 of the target; bit 1 is unaffected so the check is shared.
  assign jump_target = is_jalr ? {pc_target[31:1], 1'b0} : pc_target;
  assign next_pc     = is_jump ? target_q : pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INST;
      target_q   <= '0;
      tcnt_q     <= '0;
      cause_q    <= TrapNone;
      instret_q  <= '0;
      imem_req_q <= 1'b0;
      rf_we_q    <= 1'b0;
      halt_q     <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q    <= StFetch;
          imem_req_q <= 1'b1;
        end
        StFetch: begin
          if (imem_rvalid) begin
            ir_q       <= imem_rdata;
            tcnt_q     <= '0;
            imem_req_q <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= StDecode;
          end else if (tcnt_q == TimeoutLast) begin
            tcnt_q     <= '0;
            imem_req_q <= 1'b0;
            halt_q     <= 1'b1;
            cause_q    <= TrapAlign;
            state_q    <= StHalt;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        StDecode: begin
          if (!legal || is_ebreak) begin
            halt_q     <= 1'b1;
            ir_valid_q <= 1'b0;
            cause_q    <= is_ebreak ? TrapEbreak : TrapIllegal;
            state_q    <= StHalt;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          target_q <= jump_target;
          if (is_jump && jump_target[1]) begin
            halt_q     <= 1'b1;
            ir_valid_q <= 1'b0;
            cause_q    <= TrapAlign;
            state_q    <= StHalt;
          end else begin
            rf_we_q <= writes_rd;
            state_q <= StWb;
          end
        end
        StWb: begin
          pc_q       <= next_pc;
          instret_q  <= instret_q + 1'b1;
          rf_we_q    <= 1'b0;
          ir_valid_q <= 1'b0;
          imem_req_q <= 1'b1;
          state_q    <= StFetch;
        end
        StHalt: ;
        default: begin
          halt_q     <= 1'b1;
          imem_req_q <= 1'b0;
          rf_we_q    <= 1'b0;
          ir_valid_q <= 1'b0;
          state_q    <= StHalt;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign rf_we      = rf_we_q;
  assign halt       = halt_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Self-checking bench for npc_ctrl: directed scenarios plus randomized
// instruction streams compared against an architectural model (pc, instret,
// halt cause) derived from the instruction rules.
module tb_npc_ctrl;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int unsigned Timeout = 16;

  localparam int KAlu    = 0;
  localparam int KJal    = 1;
  localparam int KJalr   = 2;
  localparam int KEbreak = 3;
  localparam int KIll    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_target = '0;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        rf_we;
  logic        halt;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  npc_ctrl #(
    .RESET_PC      (ResetPc),
    .FETCH_TIMEOUT (Timeout),
    .CNT_W         (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_target   (pc_target),
    .pc          (pc),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .rf_we       (rf_we),
    .halt        (halt),
    .trap_cause  (trap_cause),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  logic [31:0] ill_tab [7] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_1093, 32'h0000_2067,
                               32'h0000_0073, 32'h0020_0073, 32'h0020_80B3};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reset lasts one rising edge; the state seen afterwards is IDLE.
  task automatic do_reset();
    rst = 1'b1;
    imem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_pc = ResetPc;
    m_instret = '0;
    check_eq("rst_pc", pc, ResetPc);
    check_eq("rst_instret", instret, 32'd0);
    check_eq("rst_halt", halt, 1'b0);
    check_eq("rst_cause", trap_cause, 2'd0);
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_rf_we", rf_we, 1'b0);
    check_eq("rst_ir", ir, 32'h0000_0013);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 4; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check_eq("req_seen", imem_req, 1'b1);
  endtask

  task automatic run_inst(input logic [31:0] w, input int kind, input logic [31:0] tgt,
                          input int dly, output bit halted);
    logic [4:0]  rd;
    logic [1:0]  cause;
    logic [31:0] nxt;
    bit          mis;
    bit          retire;
    int          we_cnt;
    rd     = w[11:7];
    mis    = (kind == KJal || kind == KJalr) && tgt[1];
    retire = (kind == KAlu || kind == KJal || kind == KJalr) && !mis;
    cause  = (kind == KEbreak) ? 2'd1 : (kind == KIll) ? 2'd2 : mis ? 2'd3 : 2'd0;
    case (kind)
      KJal:    nxt = tgt;
      KJalr:   nxt = tgt & 32'hFFFF_FFFE;
      default: nxt = m_pc + 32'd4;
    endcase

    wait_req();
    check_eq("fetch_addr", imem_addr, m_pc);
    pc_target = tgt;
    for (int i = 0; i < dly; i++) begin
      check_eq("req_hold", imem_req, 1'b1);
      check_eq("addr_hold", imem_addr, m_pc);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    @(negedge clk);
    // Stray response data while in DECODE and EXEC must not reach the IR.
    imem_rdata = $urandom;
    we_cnt = 0;
    for (int n = 1; n <= 4; n++) begin
      we_cnt += int'(rf_we);
      if (n == 1) begin
        check_eq("ir_load", ir, w);
        check_eq("ir_valid", ir_valid, 1'b1);
      end
      if (n == 3) begin
        imem_rvalid = 1'b0;
        check_eq("rf_we_wb", rf_we, retire && rd != 5'd0);
      end
      if (n < 4) @(negedge clk);
    end
    if (retire) begin
      m_pc = nxt;
      m_instret = m_instret + 32'd1;
    end
    halted = (cause != 2'd0);
    check_eq("rf_we_count", we_cnt, retire && rd != 5'd0);
    check_eq("pc", pc, m_pc);
    check_eq("instret", instret, m_instret);
    check_eq("halt", halt, halted);
    check_eq("trap_cause", trap_cause, cause);
    check_eq("req_next", imem_req, !halted);
    check_eq("ir_hold", ir, w);
  endtask

  task automatic gen(output logic [31:0] w, output int kind, output logic [31:0] tgt);
    int unsigned r;
    logic [4:0]  rd;
    r   = $urandom_range(0, 19);
    rd  = 5'($urandom);
    tgt = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) tgt[1] = 1'b1;
    kind = KAlu;
    if (r < 5)       w = {12'($urandom), 5'($urandom), 3'b000, rd, 7'b0010011};
    else if (r < 7)  w = {20'($urandom), rd, 7'b0110111};
    else if (r < 9)  w = {20'($urandom), rd, 7'b0010111};
    else if (r < 12) begin
      w = {20'($urandom), rd, 7'b1101111};
      kind = KJal;
    end else if (r < 15) begin
      w = {12'($urandom), 5'($urandom), 3'b000, rd, 7'b1100111};
      kind = KJalr;
    end else if (r == 15) begin
      w = 32'h0010_0073;
      kind = KEbreak;
    end else begin
      w = ill_tab[$urandom_range(0, 6)];
      kind = KIll;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          h;
    logic [31:0] w;
    logic [31:0] tgt;
    int          kind;

    @(negedge clk);
    do_reset();
    run_inst(32'h0010_0093, KAlu, 32'h0, 1, h);

    do_reset();
    for (int i = 0; i < 3; i++) run_inst(32'h0010_0093, KAlu, 32'h0, 5, h);
    check_eq("three_addi_pc", pc, 32'h8000_000C);

    do_reset();
    run_inst(32'h0000_00EF, KJal, 32'h8000_0100, 0, h);
    run_inst(32'h0001_00E7, KJalr, 32'h8000_0201, 2, h);
    run_inst(32'h0001_00E7, KJalr, 32'h8000_0206, 0, h);

    do_reset();
    run_inst(32'h0010_0073, KEbreak, 32'h0, 1, h);
    for (int i = 0; i < 20; i++) begin
      imem_rvalid = 1'($urandom);
      check_eq("halt_no_req", imem_req, 1'b0);
      check_eq("halt_sticky", halt, 1'b1);
      @(negedge clk);
    end
    imem_rvalid = 1'b0;

    do_reset();
    run_inst(32'hFFFF_FFFF, KIll, 32'h0, 0, h);

    // Fetch timeout, then reset out of HALT.
    do_reset();
    wait_req();
    for (int k = 0; k < int'(Timeout); k++) begin
      check_eq("to_req", imem_req, 1'b1);
      check_eq("to_nohalt", halt, 1'b0);
      @(negedge clk);
    end
    check_eq("to_halt", halt, 1'b1);
    check_eq("to_cause", trap_cause, 2'd3);
    check_eq("to_req_drop", imem_req, 1'b0);
    do_reset();

    // Reset mid-FETCH.
    wait_req();
    repeat (3) @(negedge clk);
    do_reset();
    run_inst(32'h0000_0013, KAlu, 32'h0, 0, h);

    // PC wraps modulo 2^32.
    run_inst(32'h0000_006F, KJal, 32'hFFFF_FFFC, 0, h);
    run_inst(32'h0010_0093, KAlu, 32'h0, 0, h);
    check_eq("pc_wrap", pc, 32'h0000_0000);

    do_reset();
    for (int i = 0; i < 120; i++) begin
      gen(w, kind, tgt);
      run_inst(w, kind, tgt, $urandom_range(0, 6), h);
      if (h) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
